// File: rtl/mem_int_if.sv
// Bus bundle between the pattern-search engine and its DDR read port / query source.
// The master modport is the engine's view; slave is the memory/host side.
interface mem_int_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 512
);
    logic                 ddr_rd;
    logic [ADDR_W-1:0]    readAdd;
    logic                 ddr_rd_done;
    logic                 ddr_rd_valid;
    logic [LINE_BITS-1:0] ddr_rd_data;
    logic [511:0]         query;
    logic                 queryValid;
    logic [ADDR_W-1:0]    locationStart;
    logic [ADDR_W-1:0]    locationEnd;
    logic                 hitTEST;

    modport master (
        output ddr_rd, readAdd, locationStart, locationEnd, hitTEST,
        input  ddr_rd_done, ddr_rd_valid, ddr_rd_data, query, queryValid
    );

    modport slave (
        input  ddr_rd, readAdd, locationStart, locationEnd, hitTEST,
        output ddr_rd_done, ddr_rd_valid, ddr_rd_data, query, queryValid
    );
endinterface

// File: rtl/mem_int.sv
// Scans DB_LINES consecutive DDR lines for a QUERY_BITS pattern at lane-aligned
// positions, one outstanding read at a time, reporting the bit address of each hit.
module mem_int #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BITS  = 512,
    parameter int QUERY_BITS = 32,
    parameter int DB_LINES   = 12
) (
    input  logic      clk,
    input  logic      rst,
    mem_int_if.master bus
);
    localparam int LANES  = LINE_BITS / QUERY_BITS;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W  = (DB_LINES > 1) ? $clog2(DB_LINES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DB_LINES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      line_idx;
    logic [QUERY_BITS-1:0] query_q;
    logic                  done_seen;

    logic                  lane_hit;
    logic [LANE_W-1:0]     hit_lane;
    logic [ADDR_W-1:0]     hit_addr;

    // NOTE: every variable gets a default before the loop, otherwise the
    // no-match path would leave it unassigned and synthesis infers a latch.
    // Scanning from the top lane down lets the lowest matching lane win.
    always_comb begin
        lane_hit = 1'b0;
        hit_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (bus.ddr_rd_data[i*QUERY_BITS +: QUERY_BITS] == query_q) begin
                lane_hit = 1'b1;
                hit_lane = LANE_W'(i);
            end
        end
    end

    assign hit_addr = bus.readAdd + ADDR_W'(hit_lane) * ADDR_W'(QUERY_BITS);

    // NOTE: non-blocking assignments throughout so every register samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            line_idx          <= '0;
            query_q           <= '0;
            done_seen         <= 1'b0;
            bus.ddr_rd        <= 1'b0;
            bus.readAdd       <= '0;
            bus.hitTEST       <= 1'b0;
            bus.locationStart <= '0;
            bus.locationEnd   <= '0;
        end else begin
            bus.ddr_rd  <= 1'b0;
            bus.hitTEST <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.queryValid) begin
                        query_q     <= bus.query[QUERY_BITS-1:0];
                        line_idx    <= '0;
                        bus.readAdd <= '0;
                        done_seen   <= 1'b0;
                        bus.ddr_rd  <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // The acknowledge may coincide with the request pulse itself.
                    done_seen <= bus.ddr_rd_done;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (bus.ddr_rd_valid) begin
                        done_seen <= 1'b0;
                        if (lane_hit) begin
                            bus.hitTEST       <= 1'b1;
                            bus.locationStart <= hit_addr;
                            bus.locationEnd   <= hit_addr + ADDR_W'(QUERY_BITS - 1);
                        end
                        if (line_idx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            line_idx    <= line_idx + IDX_W'(1);
                            bus.readAdd <= bus.readAdd + ADDR_W'(LINE_BITS);
                            bus.ddr_rd  <= 1'b1;
                            state       <= REQ;
                        end
                    end else begin
                        done_seen <= done_seen | bus.ddr_rd_done;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_int.sv
// Self-checking bench for mem_int: DDR responder with programmable read latency,
// table-driven single-hit cases, directed corner sequences and random images.
module tb_mem_int;
    localparam int ADDR_W     = 32;
    localparam int LINE_BITS  = 512;
    localparam int QUERY_BITS = 32;
    localparam int DB_LINES   = 12;
    localparam logic [511:0] ONES = {512{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_int_if #(.ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS)) bus();

    mem_int #(
        .ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS),
        .QUERY_BITS(QUERY_BITS), .DB_LINES(DB_LINES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // DDR responder: acknowledge tied to the request, data after vdelay cycles.
    logic [511:0]      mem [16];
    int                vdelay = 1;
    int                cnt = 0;
    logic [ADDR_W-1:0] pend_addr = '0;

    assign bus.ddr_rd_done = bus.ddr_rd;

    function automatic int line_of(input logic [ADDR_W-1:0] a);
        return int'(a / LINE_BITS) & 15;
    endfunction

    initial begin
        bus.ddr_rd_valid = 1'b0;
        bus.ddr_rd_data  = '0;
    end

    always @(posedge clk) begin
        bus.ddr_rd_valid <= 1'b0;
        if (rst) begin
            cnt <= 0;
        end else if (bus.ddr_rd) begin
            if (vdelay <= 1) begin
                bus.ddr_rd_valid <= 1'b1;
                bus.ddr_rd_data  <= mem[line_of(bus.readAdd)];
            end else begin
                cnt       <= vdelay - 1;
                pend_addr <= bus.readAdd;
            end
        end else if (cnt == 1) begin
            bus.ddr_rd_valid <= 1'b1;
            bus.ddr_rd_data  <= mem[line_of(pend_addr)];
            cnt              <= 0;
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end
    end

    // Observation, on the falling edge.
    int     cyc = 0;
    longint rd_q[$], rd_c[$], hit_s[$], hit_e[$], hit_c[$];
    int     vcount = 0;
    longint loc_before = 0;
    int     c0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ddr_rd) begin
            rd_q.push_back(longint'(bus.readAdd));
            rd_c.push_back(longint'(cyc));
            check("rd_while_outstanding", longint'(cnt), 0);
        end
        if (bus.ddr_rd_valid) vcount++;
        if (bus.hitTEST) begin
            hit_s.push_back(longint'(bus.locationStart));
            hit_e.push_back(longint'(bus.locationEnd));
            hit_c.push_back(longint'(cyc));
        end
    end

    task automatic clear_obs();
        rd_q.delete(); rd_c.delete();
        hit_s.delete(); hit_e.delete(); hit_c.delete();
        vcount = 0;
    endtask

    task automatic fill_ones();
        for (int k = 0; k < 16; k++) mem[k] = ONES;
    endtask

    task automatic load_spec_image();
        fill_ones();
        mem[4] = 512'h1234abcd;
        mem[9] = 512'h1234abcd;
        mem[7] = {{480{1'b1}}, 32'h1234abc0};
        mem[8] = {{500{1'b1}}, 12'h123};
    endtask

    task automatic start_query(input logic [31:0] q);
        bus.query       = {16{$urandom()}};
        bus.query[31:0] = q;
        bus.queryValid  = 1'b1;
        c0              = cyc;
    endtask

    // One full scan; inject_at >= 0 pulses a stray queryValid mid-scan.
    task automatic run_scan(input logic [31:0] q, input int dly, input int inject_at);
        int n;
        vdelay = dly;
        clear_obs();
        loc_before = longint'(bus.locationStart);
        @(negedge clk); #1;
        start_query(q);
        n = 0;
        while (vcount < DB_LINES && n < 1000) begin
            @(negedge clk); #1;
            bus.queryValid = (n == inject_at);
            if (n == inject_at) bus.query[31:0] = ~q;
            n++;
        end
        check("scan_timeout", longint'(n < 1000), 1);
        repeat (2) @(negedge clk);
        #1;
        bus.queryValid = 1'b0;
    endtask

    // Reference: every line read in order; lowest lane equal to q is a hit.
    task automatic evaluate(input logic [31:0] q);
        longint exp_s[$];
        longint final_loc;
        check("rd_count", rd_q.size(), DB_LINES);
        foreach (rd_q[k]) check("rd_addr", rd_q[k], longint'(k) * LINE_BITS);
        for (int k = 0; k < DB_LINES; k++) begin
            for (int i = 0; i < LINE_BITS / QUERY_BITS; i++) begin
                if (mem[k][32*i +: 32] == q) begin
                    exp_s.push_back(longint'(k) * LINE_BITS + 32 * i);
                    break;
                end
            end
        end
        check("hit_count", hit_s.size(), exp_s.size());
        for (int j = 0; j < exp_s.size() && j < hit_s.size(); j++) begin
            check("loc_start", hit_s[j], exp_s[j]);
            check("loc_end", hit_e[j], exp_s[j] + 31);
        end
        final_loc = (exp_s.size() > 0) ? exp_s[exp_s.size()-1] : loc_before;
        check("loc_hold", longint'(bus.locationStart), final_loc);
        check("ddr_rd_after_scan", longint'(bus.ddr_rd), 0);
    endtask

    typedef struct {
        int          line;
        int          lane;
        int          lane2;
        int          dly;
        logic [31:0] q;
        longint      exp_start;
        longint      exp_end;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] q;
        int n;

        vecs[0] = '{2,  3, -1, 1, 32'h1234abcd, 1120, 1151};
        vecs[1] = '{0,  0, -1, 1, 32'hdeadbeef, 0,    31};
        vecs[2] = '{11, 15, -1, 2, 32'h00000001, 6112, 6143};
        vecs[3] = '{5,  7, -1, 3, 32'h80000000, 2784, 2815};
        vecs[4] = '{6,  12, 9, 1, 32'h0badf00d, 3360, 3391};

        bus.query      = '0;
        bus.queryValid = 1'b0;
        fill_ones();
        repeat (3) @(negedge clk);
        #1;
        check("rst_ddr_rd", longint'(bus.ddr_rd), 0);
        check("rst_hit", longint'(bus.hitTEST), 0);
        check("rst_readAdd", longint'(bus.readAdd), 0);
        check("rst_loc_start", longint'(bus.locationStart), 0);
        check("rst_loc_end", longint'(bus.locationEnd), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_rd_without_query", rd_q.size(), 0);

        // Reference image, one-cycle memory latency: hit positions and timing.
        load_spec_image();
        run_scan(32'h1234abcd, 1, -1);
        evaluate(32'h1234abcd);
        check("spec_hit0_start", hit_s[0], 2048);
        check("spec_hit0_end", hit_e[0], 2079);
        check("spec_hit1_start", hit_s[1], 4608);
        check("spec_hit1_end", hit_e[1], 4639);
        check("spec_last_addr", rd_q[rd_q.size()-1], 5632);
        check("lat_first_rd", rd_c[0] - c0, 1);
        check("lat_hit_line4", hit_c[0] - c0, 3 + 2 * 4);
        check("lat_hit_line9", hit_c[1] - c0, 3 + 2 * 9);

        // Same image with slow data and early acknowledge.
        run_scan(32'h1234abcd, 3, -1);
        evaluate(32'h1234abcd);
        check("slow_hit0_start", hit_s[0], 2048);
        check("slow_hit1_start", hit_s[1], 4608);

        // Stray queryValid mid-scan with a different pattern.
        run_scan(32'h1234abcd, 1, 8);
        evaluate(32'h1234abcd);

        // Table of single-line placements.
        foreach (vecs[v]) begin
            fill_ones();
            mem[vecs[v].line][32*vecs[v].lane +: 32] = vecs[v].q;
            if (vecs[v].lane2 >= 0) mem[vecs[v].line][32*vecs[v].lane2 +: 32] = vecs[v].q;
            run_scan(vecs[v].q, vecs[v].dly, -1);
            check("vec_hit_count", hit_s.size(), 1);
            check("vec_loc_start", hit_s[0], vecs[v].exp_start);
            check("vec_loc_end", hit_e[0], vecs[v].exp_end);
            evaluate(vecs[v].q);
        end

        // Reset while line 5 is being requested.
        load_spec_image();
        vdelay = 1;
        clear_obs();
        @(negedge clk); #1;
        start_query(32'h1234abcd);
        n = 0;
        while (rd_q.size() < 6 && n < 200) begin
            @(negedge clk); #1;
            bus.queryValid = 1'b0;
            n++;
        end
        check("line5_timeout", longint'(n < 200), 1);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_ddr_rd", longint'(bus.ddr_rd), 0);
        check("midrst_hit", longint'(bus.hitTEST), 0);
        check("midrst_readAdd", longint'(bus.readAdd), 0);
        check("midrst_loc_start", longint'(bus.locationStart), 0);
        check("midrst_loc_end", longint'(bus.locationEnd), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_new_rd", rd_q.size(), 6);
        run_scan(32'h1234abcd, 1, -1);
        evaluate(32'h1234abcd);

        // Random images and latencies.
        for (int it = 0; it < 15; it++) begin
            q = $urandom();
            for (int k = 0; k < 16; k++) begin
                for (int i = 0; i < 16; i++) mem[k][32*i +: 32] = $urandom();
                if ($urandom_range(0, 2) == 0) mem[k][32*$urandom_range(0, 15) +: 32] = q;
                if ($urandom_range(0, 3) == 0) mem[k][32*$urandom_range(0, 15) +: 32] = q;
            end
            run_scan(q, int'($urandom_range(1, 4)), (it % 3 == 0) ? int'($urandom_range(0, 20)) : -1);
            evaluate(q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_int.md
MEM_INT -- requirements
Module: mem_int

Interface
REQ-001 Parameter ADDR_W, default 32, width of readAdd, locationStart and locationEnd.
REQ-002 Parameter LINE_BITS, default 512, DDR line width; readAdd counts in bits, so it advances by LINE_BITS per line.
REQ-003 Parameter QUERY_BITS, default 32, searched pattern width; lanes per line = LINE_BITS/QUERY_BITS = 16.
REQ-004 Parameter DB_LINES, default 12, number of lines scanned per query.
REQ-005 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port ddr_rd, output, 1, one-cycle read request for the line at readAdd.
REQ-008 Port readAdd, output, ADDR_W, bit address of the requested line (line index * LINE_BITS).
REQ-009 Port ddr_rd_done, input, 1, request acknowledge; may be asserted in the same cycle as ddr_rd.
REQ-010 Port ddr_rd_valid, input, 1, ddr_rd_data is valid this cycle.
REQ-011 Port ddr_rd_data, input, LINE_BITS, returned line.
REQ-012 Port query, input, 512, search pattern; only query[QUERY_BITS-1:0] is used.
REQ-013 Port queryValid, input, 1, one-cycle start strobe.
REQ-014 Port locationStart, output, ADDR_W, bit address of the first bit of the last hit.
REQ-015 Port locationEnd, output, ADDR_W, equals locationStart + QUERY_BITS - 1.
REQ-016 Port hitTEST, output, 1, one-cycle pulse marking a hit in the line just received.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ, WAIT.
REQ-018 IDLE: on queryValid=1, latch query[31:0], clear the line index and readAdd to 0, go to REQ; otherwise stay.
REQ-019 REQ: drive ddr_rd=1 for exactly one cycle with a stable readAdd, then go to WAIT.
REQ-020 WAIT: stay until ddr_rd_valid=1; ddr_rd_done is sticky-latched, and the line completes on ddr_rd_valid whether done arrived earlier or in the same cycle.
REQ-021 On a valid cycle, compare the latched query against all 16 aligned lanes (lane i = ddr_rd_data[32i+31:32i]).
REQ-022 Any lane equal: next cycle hitTEST=1, locationStart=readAdd+32*i for the lowest matching i, locationEnd=locationStart+31.
REQ-023 No lane equal: hitTEST=0 next cycle; location outputs hold their previous values.
REQ-024 After a valid cycle: if line index = DB_LINES-1, go to IDLE; else increment index, add LINE_BITS to readAdd, go to REQ.
REQ-025 Latency: queryValid sampled at edge t gives ddr_rd high in cycle t+1. If valid returns one cycle after ddr_rd, each line takes 2 cycles; line k's hitTEST is in cycle t+3+2k.
REQ-026 queryValid SHALL be ignored outside IDLE.
REQ-027 ddr_rd_valid and ddr_rd_done SHALL be ignored in IDLE and REQ (no outstanding request).
REQ-028 readAdd SHALL hold its value between requests.
REQ-029 hitTEST SHALL never be high for two consecutive cycles unless two consecutive lines both hit.

Reset
REQ-030 rst=1 at a clock edge, including mid-scan, forces IDLE.
REQ-031 Reset clears ddr_rd, hitTEST, readAdd, locationStart, locationEnd and the line index to 0, and clears the sticky done flag and the latched query.
REQ-032 The first request after reset SHALL come only from a new queryValid.

Verification
REQ-033 Memory model: line n = mem[readAdd/512], valid one cycle after ddr_rd, done tied to ddr_rd. Lines 4 and 9 = 0x1234abcd (upper bits 0); line 7 low word = 0x1234abc0, rest ones; line 8 low 12 bits = 0x123, rest ones; all other lines all-ones. Query 0x1234abcd. -> Exactly two hitTEST pulses: first with locationStart=2048 and locationEnd=2079, second with 4608/4639. Line 7 gives no hit.
REQ-034 Same run -> readAdd sequence 0, 512, ..., 5632; exactly 12 ddr_rd pulses; then IDLE with ddr_rd=0.
REQ-035 Query 0x1234abcd placed in lane 3 of line 2 only -> one hit with locationStart=1024+96=1120 and locationEnd=1151.
REQ-036 Valid delayed by 3 cycles after ddr_rd with done asserted early -> same hits; no second ddr_rd before valid.
REQ-037 rst asserted during line 5 -> all outputs 0 next cycle; a new queryValid restarts the scan at readAdd=0.
REQ-038 queryValid pulsed mid-scan -> ignored; the scan sequence is unchanged.
